// File: rtl/axil_wbc_bridge.sv
// AXI4-Lite slave to classic Wishbone master bridge. One transaction is in flight at a time, with fair read/write arbitration.
// Latency: the AXI handshake is in cycle 0, cyc/stb rise in cycle 1, and B/R valid rises the cycle after WB ack/err/timeout (a zero-strobe write skips the WB cycle).
// Backpressure: AXI readies are driven only in IDLE, B/R valid is held until bready/rready, and a stalled WB slave is aborted after TIMEOUT cycles.
// Ports: s_aw*/s_w*/s_b*/s_ar*/s_r* form the AXI4-Lite slave. wb_* is the classic WB master (wb_adr is a word address).
//        timeout_o pulses for one cycle on each timeout abort.
module axil_wbc_bridge #(
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int ADDR_KEEP = 32,
   parameter int TIMEOUT   = 1024,
   parameter int TW        = 11
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic [AW-1:0]              s_awaddr,
   input  logic                       s_awvalid,
   output logic                       s_awready,
   input  logic [DW-1:0]              s_wdata,
   input  logic [DW/8-1:0]            s_wstrb,
   input  logic                       s_wvalid,
   output logic                       s_wready,
   output logic [1:0]                 s_bresp,
   output logic                       s_bvalid,
   input  logic                       s_bready,
   input  logic [AW-1:0]              s_araddr,
   input  logic                       s_arvalid,
   output logic                       s_arready,
   output logic [DW-1:0]              s_rdata,
   output logic [1:0]                 s_rresp,
   output logic                       s_rvalid,
   input  logic                       s_rready,
   output logic                       wb_cyc,
   output logic                       wb_stb,
   output logic                       wb_we,
   output logic [AW-$clog2(DW/8)-1:0] wb_adr,
   output logic [DW-1:0]              wb_dat_o,
   output logic [DW/8-1:0]            wb_sel,
   input  logic [DW-1:0]              wb_dat_i,
   input  logic                       wb_ack,
   input  logic                       wb_err,
   output logic                       timeout_o
);

   localparam int SW  = DW/8;
   localparam int LSB = $clog2(SW);
   // Address bits at or above ADDR_KEEP are forced to zero before forwarding.
   localparam logic [AW-1:0] KEEP_MASK =
      (ADDR_KEEP >= AW) ? {AW{1'b1}} : AW'((64'd1 << ADDR_KEEP) - 64'd1);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {IDLE, WB_WR, WB_RD, BRESP, RRESP} state_t;

   state_t        state;
   logic          last_wr;     // 1: the last grant was a write, 0: a read (reset value)
   logic [TW-1:0] tmo_cnt;

   logic          wr_pend;
   logic          rd_pend;
   logic          grant_wr;
   logic          grant_rd;
   logic [AW-1:0] aw_masked;
   logic [AW-1:0] ar_masked;
   logic          tmo_hit;
   logic          term;
   logic          term_ok;
   logic          unused_addr_lsbs;

   always_comb begin
      wr_pend  = s_awvalid & s_wvalid;
      rd_pend  = s_arvalid;
      grant_wr = 1'b0;
      grant_rd = 1'b0;
      // A contested grant goes to the type that did not win last time.
      if (aresetn && state == IDLE) begin
         if (wr_pend && (!rd_pend || !last_wr))
            grant_wr = 1'b1;
         else if (rd_pend)
            grant_rd = 1'b1;
      end
   end

   assign s_awready = grant_wr;
   assign s_wready  = grant_wr;
   assign s_arready = grant_rd;

   assign aw_masked = s_awaddr & KEEP_MASK;
   assign ar_masked = s_araddr & KEEP_MASK;
   assign unused_addr_lsbs = ^{aw_masked[LSB-1:0], ar_masked[LSB-1:0]};

   // The counter holds N-1 during the Nth cycle of cyc. Comparing it with TIMEOUT-1
   // keeps cyc high for exactly TIMEOUT cycles.
   assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TW'(TIMEOUT - 1));
   assign term    = wb_err | wb_ack | tmo_hit;
   assign term_ok = wb_ack & ~wb_err;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state     <= IDLE;
         last_wr   <= 1'b0;
         tmo_cnt   <= '0;
         wb_cyc    <= 1'b0;
         wb_stb    <= 1'b0;
         wb_we     <= 1'b0;
         wb_adr    <= '0;
         wb_dat_o  <= '0;
         wb_sel    <= '0;
         s_bvalid  <= 1'b0;
         s_bresp   <= '0;
         s_rvalid  <= 1'b0;
         s_rresp   <= '0;
         s_rdata   <= '0;
         timeout_o <= 1'b0;
      end else begin
         timeout_o <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_wr) begin
                  last_wr  <= 1'b1;
                  wb_adr   <= aw_masked[AW-1:LSB];
                  wb_dat_o <= s_wdata;
                  wb_sel   <= s_wstrb;
                  if (s_wstrb == '0) begin
                     // A write with no byte enables has no effect, so skip the bus cycle.
                     s_bresp  <= RESP_OKAY;
                     s_bvalid <= 1'b1;
                     state    <= BRESP;
                  end else begin
                     wb_cyc  <= 1'b1;
                     wb_stb  <= 1'b1;
                     wb_we   <= 1'b1;
                     tmo_cnt <= '0;
                     state   <= WB_WR;
                  end
               end else if (grant_rd) begin
                  last_wr <= 1'b0;
                  wb_adr  <= ar_masked[AW-1:LSB];
                  wb_sel  <= {SW{1'b1}};
                  wb_cyc  <= 1'b1;
                  wb_stb  <= 1'b1;
                  wb_we   <= 1'b0;
                  tmo_cnt <= '0;
                  state   <= WB_RD;
               end
            end
            WB_WR, WB_RD: begin
               tmo_cnt <= tmo_cnt + TW'(1);
               if (term) begin
                  wb_cyc <= 1'b0;
                  wb_stb <= 1'b0;
                  wb_we  <= 1'b0;
                  // Priority is err, then ack, then timeout. The pulse fires only for a pure timeout.
                  timeout_o <= ~wb_err & ~wb_ack;
                  if (state == WB_WR) begin
                     s_bresp  <= term_ok ? RESP_OKAY : RESP_SLVERR;
                     s_bvalid <= 1'b1;
                     state    <= BRESP;
                  end else begin
                     s_rresp  <= term_ok ? RESP_OKAY : RESP_SLVERR;
                     s_rdata  <= term_ok ? wb_dat_i : '0;
                     s_rvalid <= 1'b1;
                     state    <= RRESP;
                  end
               end
            end
            BRESP: begin
               if (s_bready) begin
                  s_bvalid <= 1'b0;
                  state    <= IDLE;
               end
            end
            RRESP: begin
               if (s_rready) begin
                  s_rvalid <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axil_wbc_bridge.sv
// Testbench for axil_wbc_bridge. It drives the AXI side from tasks and runs a behavioural WB slave.
// A word-array reference model holds the expected register contents.
// Each scenario task checks its own results inline.
module tb_axil_wbc_bridge;
   localparam int AW = 32, DW = 32, ADDR_KEEP = 8, TIMEOUT = 16, TW = 5;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b1;
   logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0;
   logic [3:0]  s_wstrb = '0;
   logic        s_awvalid = 0, s_wvalid = 0, s_bready = 0, s_arvalid = 0, s_rready = 0;
   logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
   logic [1:0]  s_bresp, s_rresp;
   logic [31:0] s_rdata;
   logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_err, timeout_o;
   logic [29:0] wb_adr;
   logic [31:0] wb_dat_o, wb_dat_i;
   logic [3:0]  wb_sel;

   axil_wbc_bridge #(.AW(AW), .DW(DW), .ADDR_KEEP(ADDR_KEEP), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
      .wb_dat_o(wb_dat_o), .wb_sel(wb_sel), .wb_dat_i(wb_dat_i),
      .wb_ack(wb_ack), .wb_err(wb_err), .timeout_o(timeout_o));

   always #5 aclk = ~aclk;

   int n_vec = 0, n_err = 0;
   int cyc_n = 0;
   always @(posedge aclk) cyc_n <= cyc_n + 1;

   // Behavioural WB slave. Mode 0 never answers, mode 1 acks, mode 2 errs, each after slv_ws wait states.
   int          slv_mode = 1, slv_ws = 0, wcnt = 0;
   logic        slv_force = 1'b0;
   logic [31:0] slv_rdata = '0;
   logic [31:0] slv_mem [64] = '{default: '0};
   assign wb_ack   = wb_cyc && wb_stb && slv_mode == 1 && wcnt >= slv_ws;
   assign wb_err   = wb_cyc && wb_stb && slv_mode == 2 && wcnt >= slv_ws;
   assign wb_dat_i = slv_force ? slv_rdata : slv_mem[wb_adr[5:0]];
   always @(posedge aclk) begin
      if (wb_cyc && wb_stb && !wb_ack && !wb_err) wcnt <= wcnt + 1; else wcnt <= 0;
      if (wb_ack && wb_we)
         for (int b = 0; b < 4; b++) if (wb_sel[b]) slv_mem[wb_adr[5:0]][8*b +: 8] <= wb_dat_o[8*b +: 8];
   end

   // Bus monitor: counts cycles with cyc high and timeout pulses, and captures each request.
   int          cyc_cnt = 0, to_cnt = 0;
   logic        prev_cyc = 1'b0, cap_we = 1'b0;
   logic [29:0] cap_adr = '0;
   logic [3:0]  cap_sel = '0;
   logic [31:0] cap_dat = '0;
   int          we_q[$];
   always @(negedge aclk) begin
      if (wb_cyc) begin
         cyc_cnt++;
         if (!prev_cyc) begin
            cap_adr = wb_adr; cap_sel = wb_sel; cap_dat = wb_dat_o; cap_we = wb_we;
            we_q.push_back(int'(wb_we));
         end
      end
      if (timeout_o) to_cnt++;
      prev_cyc = wb_cyc;
   end

   // Reference model: register words indexed by the forwarded address bits.
   logic [31:0] ref_mem [64] = '{default: '0};
   function automatic int widx(input logic [31:0] a);
      return int'((a % (32'd1 << ADDR_KEEP)) / 4);
   endfunction
   task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
      for (int b = 0; b < 4; b++) if (st[b]) ref_mem[widx(a)][8*b +: 8] = d[8*b +: 8];
   endtask

   // AXI drivers. Call them just after a rising edge. They sample on falling edges.
   // lat is the cycle distance from the address handshake to the first B/R valid (-1 if it never came).
   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                            output logic [1:0] resp, output int lat);
      int g, hs;
      lat = -1; resp = 2'b11; cyc_cnt = 0;
      s_awaddr = a; s_wdata = d; s_wstrb = st; s_awvalid = 1; s_wvalid = 1;
      g = 0; @(negedge aclk);
      while (!(s_awready && s_wready) && g < 64) begin @(negedge aclk); g++; end
      hs = cyc_n;
      @(posedge aclk); #1; s_awvalid = 0; s_wvalid = 0;
      if (g >= 64) return;
      g = 0; @(negedge aclk);
      while (!s_bvalid && g < 2000) begin @(negedge aclk); g++; end
      if (g >= 2000) return;
      lat = cyc_n - hs; resp = s_bresp;
      s_bready = 1;
      @(posedge aclk); #1; s_bready = 0;
   endtask

   task automatic axi_read(input logic [31:0] a, input int rdly, output logic [31:0] data,
                           output logic [1:0] resp, output int lat, output bit held);
      int g, hs;
      lat = -1; resp = 2'b11; data = '0; held = 1; cyc_cnt = 0;
      s_araddr = a; s_arvalid = 1;
      g = 0; @(negedge aclk);
      while (!s_arready && g < 64) begin @(negedge aclk); g++; end
      hs = cyc_n;
      @(posedge aclk); #1; s_arvalid = 0;
      if (g >= 64) return;
      g = 0; @(negedge aclk);
      while (!s_rvalid && g < 2000) begin @(negedge aclk); g++; end
      if (g >= 2000) return;
      lat = cyc_n - hs; data = s_rdata; resp = s_rresp;
      for (int i = 0; i < rdly; i++) begin
         @(negedge aclk);
         if (!s_rvalid || s_rdata !== data) held = 0;
      end
      s_rready = 1;
      @(posedge aclk); #1; s_rready = 0;
   endtask

   task automatic test_reset;
      #1 aresetn = 0;
      s_awvalid = 1; s_wvalid = 1; s_arvalid = 1;
      #2;
      n_vec++; if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid} !== 5'b0) begin n_err++; $display("FAIL reset_handshake: got %b want 00000", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid}); end
      n_vec++; if ({wb_cyc, wb_stb, wb_we, timeout_o} !== 4'b0) begin n_err++; $display("FAIL reset_wb_ctrl: got %b want 0000", {wb_cyc, wb_stb, wb_we, timeout_o}); end
      n_vec++; if ({wb_adr, wb_dat_o, wb_sel} !== '0) begin n_err++; $display("FAIL reset_wb_data: got %h %h %h want 0", wb_adr, wb_dat_o, wb_sel); end
      n_vec++; if ({s_rdata, s_bresp, s_rresp} !== '0) begin n_err++; $display("FAIL reset_resp: got %h %b %b want 0", s_rdata, s_bresp, s_rresp); end
      s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
      @(negedge aclk); aresetn = 1;
      @(posedge aclk); #1;
   endtask

   task automatic test_write_basic;
      logic [1:0] r; int lat;
      slv_mode = 1; slv_ws = 0;
      axi_write(32'h1F04, 32'h12345678, 4'hF, r, lat);
      ref_write(32'h1F04, 32'h12345678, 4'hF);
      n_vec++; if (lat !== 2) begin n_err++; $display("FAIL wr_latency: got %0d want 2", lat); end
      n_vec++; if (r !== 2'b00) begin n_err++; $display("FAIL wr_bresp: got %b want 00", r); end
      n_vec++; if (cyc_cnt !== 1) begin n_err++; $display("FAIL wr_cyc_len: got %0d want 1", cyc_cnt); end
      n_vec++; if (cap_adr !== 30'h1) begin n_err++; $display("FAIL wr_adr: got %h want 1", cap_adr); end
      n_vec++; if ({cap_we, cap_sel, cap_dat} !== {1'b1, 4'hF, 32'h12345678}) begin n_err++; $display("FAIL wr_req: got %b %h %h want 1 f 12345678", cap_we, cap_sel, cap_dat); end
   endtask

   task automatic test_read_wait;
      logic [1:0] r; logic [31:0] d; int lat; bit held;
      slv_mode = 1; slv_ws = 3; slv_force = 1; slv_rdata = 32'hCAFEF00D;
      axi_read(32'h08, 5, d, r, lat, held);
      slv_force = 0;
      n_vec++; if (cyc_cnt !== 4) begin n_err++; $display("FAIL rd_cyc_len: got %0d want 4", cyc_cnt); end
      n_vec++; if (lat !== 5) begin n_err++; $display("FAIL rd_latency: got %0d want 5", lat); end
      n_vec++; if (d !== 32'hCAFEF00D) begin n_err++; $display("FAIL rd_data: got %h want cafef00d", d); end
      n_vec++; if (r !== 2'b00) begin n_err++; $display("FAIL rd_rresp: got %b want 00", r); end
      n_vec++; if (held !== 1'b1) begin n_err++; $display("FAIL rd_hold: got %b want 1", held); end
      n_vec++; if ({cap_we, cap_sel, cap_adr} !== {1'b0, 4'hF, 30'h2}) begin n_err++; $display("FAIL rd_req: got %b %h %h want 0 f 2", cap_we, cap_sel, cap_adr); end
   endtask

   // Both request types are held pending at once, starting from reset, so the arbiter must alternate.
   task automatic test_arbitration;
      int gq[$]; int g, got_w, got_r; bit hs_w, hs_r;
      logic [31:0] wa, wd; logic [3:0] ws;
      slv_mode = 1; slv_ws = 0;
      aresetn = 0; #3 aresetn = 1;
      we_q.delete();
      s_bready = 1; s_rready = 1;
      for (int rep = 0; rep < 2; rep++) begin
         wa = $urandom & 32'hFFFF_FFFC; wd = $urandom; ws = 4'($urandom_range(1, 15));
         s_awaddr = wa; s_wdata = wd; s_wstrb = ws; s_awvalid = 1; s_wvalid = 1;
         s_araddr = $urandom & 32'hFFFF_FFFC; s_arvalid = 1;
         got_w = 0; got_r = 0; g = 0;
         while (!(got_w && got_r) && g < 100) begin
            @(negedge aclk);
            hs_w = s_awready; hs_r = s_arready;
            if (hs_w) gq.push_back(1);
            if (hs_r) gq.push_back(0);
            @(posedge aclk); #1;
            if (hs_w) begin s_awvalid = 0; s_wvalid = 0; got_w = 1; ref_write(wa, wd, ws); end
            if (hs_r) begin s_arvalid = 0; got_r = 1; end
            g++;
         end
      end
      s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
      repeat (3) @(posedge aclk);
      #1; s_bready = 0; s_rready = 0;
      n_vec++; if (gq.size() !== 4) begin n_err++; $display("FAIL arb_count: got %0d want 4", gq.size()); end
      for (int i = 0; i < 4; i++) begin
         n_vec++; if (i >= gq.size() || gq[i] !== ((i % 2 == 0) ? 1 : 0)) begin n_err++; $display("FAIL arb_order[%0d]: got %0d want %0d", i, (i < gq.size()) ? gq[i] : -1, (i % 2 == 0) ? 1 : 0); end
         n_vec++; if (i >= we_q.size() || we_q[i] !== ((i % 2 == 0) ? 1 : 0)) begin n_err++; $display("FAIL arb_we[%0d]: got %0d want %0d", i, (i < we_q.size()) ? we_q[i] : -1, (i % 2 == 0) ? 1 : 0); end
      end
   endtask

   task automatic test_timeout;
      logic [1:0] r; logic [31:0] d; int lat; bit held;
      slv_mode = 0; to_cnt = 0;
      axi_read(32'h10, 0, d, r, lat, held);
      n_vec++; if (cyc_cnt !== TIMEOUT) begin n_err++; $display("FAIL to_cyc_len: got %0d want %0d", cyc_cnt, TIMEOUT); end
      n_vec++; if (lat !== TIMEOUT + 1) begin n_err++; $display("FAIL to_latency: got %0d want %0d", lat, TIMEOUT + 1); end
      n_vec++; if (to_cnt !== 1) begin n_err++; $display("FAIL to_pulse: got %0d want 1", to_cnt); end
      n_vec++; if ({r, d} !== {2'b10, 32'h0}) begin n_err++; $display("FAIL to_resp: got %b %h want 10 0", r, d); end
      slv_mode = 1; slv_ws = 0;
      axi_write(32'h20, 32'hA5A5_0F0F, 4'h5, r, lat);
      ref_write(32'h20, 32'hA5A5_0F0F, 4'h5);
      n_vec++; if ({r, lat} !== {2'b00, 32'd2}) begin n_err++; $display("FAIL to_recover: got %b %0d want 00 2", r, lat); end
      // The ack lands on the final allowed cycle and must win over the timeout.
      slv_ws = TIMEOUT - 1;
      axi_read(32'h20, 0, d, r, lat, held);
      n_vec++; if ({r, d} !== {2'b00, ref_mem[widx(32'h20)]}) begin n_err++; $display("FAIL to_ack_wins: got %b %h want 00 %h", r, d, ref_mem[widx(32'h20)]); end
      n_vec++; if (to_cnt !== 1 || lat !== TIMEOUT + 1) begin n_err++; $display("FAIL to_ack_wins_pulse: got %0d %0d want 1 %0d", to_cnt, lat, TIMEOUT + 1); end
   endtask

   task automatic test_err_and_zero_strobe;
      logic [1:0] r; int lat;
      slv_mode = 2; slv_ws = 1;
      axi_write(32'h30, 32'hDEAD_BEEF, 4'hF, r, lat);
      n_vec++; if ({r, lat} !== {2'b10, 32'd3}) begin n_err++; $display("FAIL err_bresp: got %b %0d want 10 3", r, lat); end
      slv_mode = 1; slv_ws = 0;
      axi_write(32'h34, 32'h1111_2222, 4'h0, r, lat);
      n_vec++; if ({r, lat} !== {2'b00, 32'd1}) begin n_err++; $display("FAIL zs_bresp: got %b %0d want 00 1", r, lat); end
      n_vec++; if (cyc_cnt !== 0) begin n_err++; $display("FAIL zs_no_cyc: got %0d want 0", cyc_cnt); end
   endtask

   task automatic test_reset_mid;
      logic [1:0] r; logic [31:0] d; int lat, g; bit held;
      slv_mode = 0;
      s_araddr = 32'h44; s_arvalid = 1;
      g = 0; @(negedge aclk);
      while (!s_arready && g < 64) begin @(negedge aclk); g++; end
      @(posedge aclk); #1; s_arvalid = 0;
      repeat (2) @(posedge aclk);
      #1;
      n_vec++; if (wb_cyc !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %b want 1", wb_cyc); end
      #2 aresetn = 0;
      #1;
      n_vec++; if ({wb_cyc, wb_stb, s_rvalid} !== 3'b0) begin n_err++; $display("FAIL mid_async: got %b want 000", {wb_cyc, wb_stb, s_rvalid}); end
      @(negedge aclk); aresetn = 1;
      @(posedge aclk); #1;
      slv_mode = 1; slv_ws = 0;
      axi_read(32'h04, 0, d, r, lat, held);
      n_vec++; if ({r, d, lat} !== {2'b00, ref_mem[1], 32'd2}) begin n_err++; $display("FAIL mid_recover: got %b %h %0d want 00 %h 2", r, d, lat, ref_mem[1]); end
   endtask

   task automatic test_random;
      logic [1:0] r; logic [31:0] a, d, got; logic [3:0] st; int lat, rdly, ecyc, elat; bit held;
      slv_mode = 1;
      for (int it = 0; it < 40; it++) begin
         slv_ws = $urandom_range(0, 3);
         a = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom; st = 4'($urandom_range(0, 15));
            ecyc = (st == 4'h0) ? 0 : slv_ws + 1;
            elat = (st == 4'h0) ? 1 : slv_ws + 2;
            axi_write(a, d, st, r, lat);
            ref_write(a, d, st);
            n_vec++; if ({r, lat, cyc_cnt} !== {2'b00, elat, ecyc}) begin n_err++; $display("FAIL rnd_wr[%0d]: got %b %0d %0d want 00 %0d %0d", it, r, lat, cyc_cnt, elat, ecyc); end
            if (st != 4'h0) begin
               n_vec++; if ({cap_we, cap_adr, cap_sel, cap_dat} !== {1'b1, 30'(widx(a)), st, d}) begin n_err++; $display("FAIL rnd_wr_req[%0d]: got %h %h %h want %h %h %h", it, cap_adr, cap_sel, cap_dat, widx(a), st, d); end
            end
         end else begin
            rdly = $urandom_range(0, 3);
            axi_read(a, rdly, got, r, lat, held);
            n_vec++; if ({r, got} !== {2'b00, ref_mem[widx(a)]}) begin n_err++; $display("FAIL rnd_rd[%0d]: got %b %h want 00 %h", it, r, got, ref_mem[widx(a)]); end
            n_vec++; if ({lat, cyc_cnt} !== {slv_ws + 2, slv_ws + 1} || !held) begin n_err++; $display("FAIL rnd_rd_timing[%0d]: got %0d %0d %b want %0d %0d 1", it, lat, cyc_cnt, held, slv_ws + 2, slv_ws + 1); end
         end
      end
   endtask

   initial begin
      test_reset;
      test_write_basic;
      test_read_wait;
      test_arbitration;
      test_timeout;
      test_err_and_zero_strobe;
      test_reset_mid;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
endmodule
